// File: rtl/ahb_pkg.sv
// Shared AHB types for the round-robin bus arbiter: HTRANS encoding, arbiter state, widths.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } HTRANS_state;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 8;

    // A beat that moves data (counts toward the hold budget and validates the data phase).
    function automatic logic htrans_active(HTRANS_state t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after start_i, wrapping modulo N.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Outer loop is the round-robin distance, so the nearest requester wins.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found_o && req_i[i] && (((32'(start_i) + k) % N) == i)) begin
                    found_o     = 1'b1;
                    winner_o[i] = 1'b1;
                    idx_o       = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with hold budget, locked sequences and data-phase owner tracking.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [N_MASTERS-1:0]      master_req,
    input  logic [N_MASTERS-1:0]      master_lock,
    input  logic [N_MASTERS-1:0][1:0] master_htrans,
    input  logic                      HREADY,
    output logic [N_MASTERS-1:0]      grant,
    output logic [1:0]                hmaster,
    output logic [1:0]                hmaster_data,
    output logic                      data_valid,
    output logic                      hmastlock
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_e            state_q, state_d;
    logic [N_MASTERS-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]      hmaster_q, hmaster_d;
    logic [IDX_W-1:0]      hmaster_data_q, hmaster_data_d;
    logic [IDX_W-1:0]      last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  data_valid_q, data_valid_d;

    logic                  own_req;
    logic                  own_lock;
    HTRANS_state           own_htrans;
    logic                  other_req;
    logic                  release_c;
    logic                  force_c;
    logic [IDX_W-1:0]      rr_base;
    logic [IDX_W-1:0]      rr_start;
    logic [N_MASTERS-1:0]  pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;

    // Only the current owner's request, lock and HTRANS influence arbitration.
    always_comb begin
        own_req    = 1'b0;
        own_lock   = 1'b0;
        own_htrans = IDLE;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (hmaster_q == IDX_W'(i)) begin
                own_req    = master_req[i];
                own_lock   = master_lock[i];
                own_htrans = HTRANS_state'(master_htrans[i]);
            end
        end
    end

    assign other_req = |(master_req & ~grant_q);
    assign release_c = !own_req && (own_htrans == IDLE);
    assign force_c   = (hold_q == HOLD_MAX) && !own_lock && other_req &&
                       ((own_htrans == IDLE) || (own_htrans == NONSEQ));

    // Search starts just past the owner, or past the previous owner when the bus is idle.
    assign rr_base  = (state_q == ARB_OWN) ? hmaster_q : last_owner_q;
    assign rr_start = (rr_base == LAST_IDX) ? '0 : rr_base + IDX_W'(1);

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req_i    (master_req),
        .start_i  (rr_start),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        last_owner_d   = last_owner_q;
        hold_d         = hold_q;
        data_valid_d   = data_valid_q;

        if (HREADY) begin
            hmaster_data_d = hmaster_q;
            data_valid_d   = (state_q == ARB_OWN) && htrans_active(own_htrans);

            if (state_q == ARB_IDLE || release_c || force_c) begin
                if (pick_found) begin
                    state_d      = ARB_OWN;
                    grant_d      = pick_onehot;
                    hmaster_d    = pick_idx;
                    last_owner_d = pick_idx;
                    hold_d       = '0;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            end else if (htrans_active(own_htrans) && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= ARB_IDLE;
            grant_q        <= '0;
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
            last_owner_q   <= LAST_IDX;
            hold_q         <= '0;
            data_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            last_owner_q   <= last_owner_d;
            hold_q         <= hold_d;
            data_valid_q   <= data_valid_d;
        end
    end

    assign grant        = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign data_valid   = data_valid_q;
    // Lock follows the owner's live request so a dropped lock frees the bus at the next beat.
    assign hmastlock    = (state_q == ARB_OWN) && own_lock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_ahb_rr_arbiter;

    localparam int N  = 3;
    localparam int MH = 4;
    localparam logic [1:0] TI = 2'd0, TB = 2'd1, TN = 2'd2, TS = 2'd3;

    logic              HCLK;
    logic              HRESETn;
    logic [N-1:0]      master_req;
    logic [N-1:0]      master_lock;
    logic [N-1:0][1:0] master_htrans;
    logic              HREADY;
    logic [N-1:0]      grant;
    logic [1:0]        hmaster;
    logic [1:0]        hmaster_data;
    logic              data_valid;
    logic              hmastlock;

    ahb_rr_arbiter #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .master_req    (master_req),
        .master_lock   (master_lock),
        .master_htrans (master_htrans),
        .HREADY        (HREADY),
        .grant         (grant),
        .hmaster       (hmaster),
        .hmaster_data  (hmaster_data),
        .data_valid    (data_valid),
        .hmastlock     (hmastlock)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   hm;
        logic [1:0]   hmd;
        logic         dv;
        logic         lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    // Reference model: owner is -1 when nobody holds the bus.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;
    int m_hm    = 0;
    int m_down  = 0;
    bit m_dv    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    function automatic int ht_of(input logic [5:0] ht, input int m);
        return int'(ht[m*2 +: 2]);
    endfunction

    function automatic logic [5:0] H(input logic [1:0] h0, input logic [1:0] h1, input logic [1:0] h2);
        return {h2, h1, h0};
    endfunction

    function automatic int rr_search(input int start, input logic [N-1:0] rq);
        for (int k = 0; k < N; k++) begin
            if (rq[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] lk,
                              input logic [5:0] ht, input logic hr, input logic rn);
        int  w;
        int  oht;
        bit  others;
        bit  rel;
        bit  frc;
        if (!rn) begin
            m_owner = -1; m_last = N - 1; m_beats = 0; m_hm = 0; m_down = 0; m_dv = 1'b0;
        end else if (hr) begin
            oht    = (m_owner >= 0) ? ht_of(ht, m_owner) : 0;
            m_dv   = (m_owner >= 0) && (oht >= 2);
            m_down = m_hm;
            if (m_owner < 0) begin
                w = rr_search((m_last + 1) % N, rq);
                if (w >= 0) begin
                    m_owner = w; m_hm = w; m_last = w; m_beats = 0;
                end
            end else begin
                others = 1'b0;
                for (int j = 0; j < N; j++) if (j != m_owner && rq[j]) others = 1'b1;
                rel = !rq[m_owner] && (oht == 0);
                frc = (m_beats == MH - 1) && (oht == 0 || oht == 2) && !lk[m_owner] && others;
                if (rel || frc) begin
                    w = rr_search((m_owner + 1) % N, rq);
                    m_beats = 0;
                    if (w >= 0) begin
                        m_owner = w; m_hm = w; m_last = w;
                    end else begin
                        m_owner = -1;
                    end
                end else if (oht >= 2 && m_beats < MH - 1) begin
                    m_beats++;
                end
            end
        end
    endtask

    // One bus cycle: drive at negedge, predict the post-edge outputs and queue them.
    task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [5:0] ht, input logic hr, input logic rn);
        exp_t e;
        @(negedge HCLK);
        master_req    = rq;
        master_lock   = lk;
        master_htrans = ht;
        HREADY        = hr;
        HRESETn       = rn;
        if (!rn) begin
            #1;
            chk("async_rst_grant", int'(grant), 0);
            chk("async_rst_dvalid", int'(data_valid), 0);
            chk("async_rst_hmastlock", int'(hmastlock), 0);
        end
        model_step(rq, lk, ht, hr, rn);
        e.grant = '0;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.hm   = 2'(m_hm);
        e.hmd  = 2'(m_down);
        e.dv   = m_dv;
        e.lock = (m_owner >= 0) && lk[m_owner];
        exp_q.push_back(e);
    endtask

    // Monitor: compares each post-edge output set against the oldest prediction.
    always @(posedge HCLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",        int'(grant),        int'(e.grant));
            chk("hmaster",      int'(hmaster),      int'(e.hm));
            chk("hmaster_data", int'(hmaster_data), int'(e.hmd));
            chk("data_valid",   int'(data_valid),   int'(e.dv));
            chk("hmastlock",    int'(hmastlock),    int'(e.lock));
        end
    end

    initial begin
        HRESETn       = 1'b0;
        master_req    = '0;
        master_lock   = '0;
        master_htrans = '0;
        HREADY        = 1'b1;

        repeat (3) cyc(3'b000, 3'b000, H(TI, TI, TI), 1'b1, 1'b0);
        // Release: 110 grants M1, then M1 drops with IDLE and M2 takes over.
        cyc(3'b110, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);
        cyc(3'b100, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);

        // M0 SEQ burst with M1 waiting: never split on SEQ, switch on the next NONSEQ.
        cyc(3'b001, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);
        cyc(3'b011, 3'b000, H(TN, TI, TI), 1'b1, 1'b1);
        repeat (5) cyc(3'b011, 3'b000, H(TS, TI, TI), 1'b1, 1'b1);
        cyc(3'b011, 3'b000, H(TN, TI, TI), 1'b1, 1'b1);

        // M1 exhausts its budget, switch is stalled by three wait states.
        repeat (3) cyc(3'b011, 3'b000, H(TI, TN, TI), 1'b1, 1'b1);
        repeat (3) cyc(3'b011, 3'b000, H(TI, TN, TI), 1'b0, 1'b1);
        cyc(3'b011, 3'b000, H(TI, TN, TI), 1'b1, 1'b1);
        cyc(3'b011, 3'b000, H(TN, TI, TI), 1'b1, 1'b1);

        // Locked M2 keeps the bus past its budget until the lock drops.
        cyc(3'b100, 3'b100, H(TI, TI, TI), 1'b1, 1'b1);
        repeat (6) cyc(3'b101, 3'b100, H(TI, TI, TN), 1'b1, 1'b1);
        cyc(3'b101, 3'b000, H(TI, TI, TN), 1'b1, 1'b1);

        // Reset lands in the middle of an M0 burst.
        cyc(3'b001, 3'b000, H(TN, TI, TI), 1'b1, 1'b1);
        cyc(3'b001, 3'b000, H(TS, TI, TI), 1'b1, 1'b1);
        cyc(3'b001, 3'b000, H(TS, TI, TI), 1'b1, 1'b0);
        cyc(3'b000, 3'b000, H(TI, TI, TI), 1'b1, 1'b0);

        // Everyone requesting: rotation 001, 010, 100, 001.
        cyc(3'b111, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);
        repeat (4) begin
            repeat (3) cyc(3'b111, 3'b000, H(TN, TN, TN), 1'b1, 1'b1);
            cyc(3'b111, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rq;
            logic [N-1:0] lk;
            logic [5:0]   ht;
            for (int j = 0; j < N; j++) begin
                rq[j] = ($urandom_range(0, 9) < 6);
                lk[j] = ($urandom_range(0, 9) < 2);
            end
            ht = 6'($urandom);
            cyc(rq, lk, ht, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end

        cyc(3'b000, 3'b000, H(TI, TI, TI), 1'b1, 1'b1);
        @(posedge HCLK);
        #3;
        chk("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3, number of requesting masters (2..4).
REQ-002 SHALL have parameter MAX_HOLD, default 16, number of HREADY-accepted beats before forced re-arbitration (2..255).
REQ-003 SHALL have port HCLK  input  1  single clock, rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port master_req  input  N_MASTERS  bus request per master.
REQ-006 SHALL have port master_lock  input  N_MASTERS  locked-sequence request per master.
REQ-007 SHALL have port master_htrans  input  N_MASTERS x HTRANS_state  per-master address-phase HTRANS.
REQ-008 SHALL have port HREADY  input  1  bus HREADY from the slave mux.
REQ-009 SHALL have port grant  output  N_MASTERS  one-hot address-phase grant; all-zero when no owner.
REQ-010 SHALL have port hmaster  output  2  index of address-phase owner.
REQ-011 SHALL have port hmaster_data  output  2  index of data-phase owner.
REQ-012 SHALL have port data_valid  output  1  data phase currently carries a real transfer.
REQ-013 SHALL have port hmastlock  output  1  owner's master_lock while granted.

Function
REQ-014 SHALL implement FSM {ARB_IDLE, ARB_OWN}; grant is all-zero in ARB_IDLE and one-hot in ARB_OWN.
REQ-015 SHALL leave ARB_IDLE for ARB_OWN at the first edge where any master_req=1; the winner is chosen round-robin starting at index (last_owner+1) mod N_MASTERS.
REQ-016 SHALL allow ownership changes only at edges where HREADY=1; with HREADY=0, grant, hmaster and hold_cnt hold.
REQ-017 SHALL re-arbitrate in ARB_OWN when HREADY=1 and the owner has master_req=0 and owner HTRANS==IDLE.
REQ-018 SHALL also re-arbitrate when HREADY=1, hold_cnt==MAX_HOLD-1, owner HTRANS in {IDLE,NONSEQ}, owner master_lock=0, and another master_req=1; SEQ and BUSY beats are never split.
REQ-019 SHALL, on re-arbitration, grant the next requester round-robin after the current owner, re-grant the owner if it is the sole requester, or go to ARB_IDLE if no request is pending.
REQ-020 SHALL keep hold_cnt (8 bits): cleared on every new grant, incremented on each HREADY=1 edge with owner HTRANS in {NONSEQ,SEQ}, saturating at MAX_HOLD-1.
REQ-021 SHALL update last_owner to hmaster on every grant change.
REQ-022 SHALL, on each HREADY=1 edge, load hmaster_data<=hmaster and data_valid<=(state==ARB_OWN and owner HTRANS in {NONSEQ,SEQ}); both hold while HREADY=0.
REQ-023 SHALL drive hmastlock = master_lock[hmaster] in ARB_OWN, else 0; while it is 1, REQ-018 is suppressed.
REQ-024 SHALL ignore master_htrans and master_lock of non-owners.
REQ-025 SHALL resolve simultaneous owner release and new requests in the same cycle by round-robin order alone, with no idle cycle between owners.
REQ-026 SHALL make hmaster hold its last value in ARB_IDLE.

Reset
REQ-027 SHALL, while HRESETn=0, force state=ARB_IDLE, grant=0, hmaster=0, hmaster_data=0, data_valid=0, hmastlock=0, hold_cnt=0, last_owner=N_MASTERS-1; a reset asserted mid-burst takes effect immediately without waiting for HREADY.
REQ-028 SHALL treat the first post-reset arbitration as starting from index 0.

Structure
REQ-029 SHALL import HTRANS_state (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and the arbiter state enum from the shared package ahb_pkg.
REQ-030 SHALL place round-robin selection in sub-module rr_pick (inputs: request vector, start index; outputs: one-hot winner, index, found); it is purely combinational.

Verification
REQ-031 SHALL cover: reset release, master_req=3'b110 -> grant=3'b010 next edge; then owner drops req with HTRANS=IDLE -> grant=3'b100 next edge.
REQ-032 SHALL cover: M0 running a SEQ burst, M1 requesting, MAX_HOLD=4 -> no switch during SEQ; switch to M1 at the first NONSEQ/IDLE beat after hold_cnt reaches 3.
REQ-033 SHALL cover: switch due while HREADY=0 for 3 cycles -> grant held, switch on the first HREADY=1 edge; hmaster_data lags hmaster by exactly one accepted beat.
REQ-034 SHALL cover: M2 with master_lock=1 and hold_cnt saturated, M0 requesting -> M2 keeps grant until master_lock=0.
REQ-035 SHALL cover: HRESETn asserted mid-burst with grant=3'b001 -> grant=0 and data_valid=0 before the next HCLK edge.
REQ-036 SHALL cover: all three requesting continuously with HTRANS=IDLE after each beat -> grant order 001, 010, 100, 001.
